// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the sequencer state encoding, the operation select, the operand
// width and latency constants, and a helper that forms the 33-bit
// unsigned magnitude of a signed operand (so INT_MIN maps to 2^31).
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int LATENCY = 33;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

  // One extra bit so that |INT_MIN| = 2^31 is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational iteration of unsigned restoring division.
// Ports:
//   rem_in  - partial remainder from the previous iteration
//   bit_in  - next dividend bit shifted into the remainder
//   div_in  - divisor magnitude
//   rem_out - partial remainder for the next iteration
//   q_bit   - quotient bit produced by this iteration
module restoring_div_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] div_in,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // The remainder stays below the divisor (at most 2^31), so dropping the
  // top bit before the shift loses nothing.
  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  assign diff    = {1'b0, shifted} - {1'b0, div_in};

  always_comb begin
    if (diff[WIDTH+1]) begin
      rem_out = shifted;
      q_bit   = 1'b0;
    end else begin
      rem_out = diff[WIDTH:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// A start pulse latches both operands; the result and exception flag are
// registered and announced with a one-cycle ready pulse 33 edges later.
// Ports:
//   clock, reset_n         - rising-edge clock, async active-low reset
//   ctrl_MULT, ctrl_DIV    - start pulses (multiply wins if both are high)
//   data_operandA/B        - signed multiplicand/dividend, multiplier/divisor
//   data_result            - signed result, held until the next ready pulse
//   data_exception         - overflow / divide-by-zero, held with the result
//   data_resultRDY         - one-cycle ready pulse
//   busy                   - high from the start edge until the ready edge
//
// state | meaning
// IDLE  | waiting for a start pulse
// MUL   | one Booth step per edge
// DIV   | one restoring-division step per edge
// DONE  | register result, pulse ready, return to IDLE
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int ITER = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t             state;
  op_t                op_q;
  logic [5:0]         counter;
  logic [5:0]         counter_next;

  // Booth register: {upper accumulator (33b), multiplier (32b), q[-1]}.
  logic [2*WIDTH+1:0] acc;
  logic [WIDTH:0]     mcand;
  logic [WIDTH:0]     booth_up;
  logic [2*WIDTH-1:0] product;
  logic               mul_ovf;

  logic [WIDTH:0]     rem_q;
  logic [WIDTH:0]     dvsr_q;
  logic [WIDTH-1:0]   quo_q;
  logic               neg_q;
  logic               divz_q;
  logic               dovf_q;
  logic [WIDTH:0]     rem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   div_res;

  logic               start;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;

  assign start        = ctrl_MULT | ctrl_DIV;
  assign counter_next = counter + 6'd1;
  assign mag_a        = magnitude(data_operandA);
  assign mag_b        = magnitude(data_operandB);

  always_comb begin
    case (acc[1:0])
      2'b01:   booth_up = acc[2*WIDTH+1:WIDTH+1] + mcand;
      2'b10:   booth_up = acc[2*WIDTH+1:WIDTH+1] - mcand;
      default: booth_up = acc[2*WIDTH+1:WIDTH+1];
    endcase
  end

  assign product = acc[2*WIDTH:1];
  // Signed overflow: bits [63:31] must all match the result sign.
  assign mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));

  restoring_div_step u_div_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .div_in  (dvsr_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Dividend bits shift out of quo_q's top while quotient bits shift in.
  assign div_res = divz_q ? '0 : (neg_q ? (~quo_q + 1'b1) : quo_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op_q           <= OP_MUL;
      counter        <= '0;
      acc            <= '0;
      mcand          <= '0;
      rem_q          <= '0;
      dvsr_q         <= '0;
      quo_q          <= '0;
      neg_q          <= 1'b0;
      divz_q         <= 1'b0;
      dovf_q         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start in any state, including mid-operation, restarts.
        state   <= ctrl_MULT ? MUL : DIV;
        op_q    <= ctrl_MULT ? OP_MUL : OP_DIV;
        counter <= '0;
        busy    <= 1'b1;
        acc     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
        mcand   <= {data_operandA[WIDTH-1], data_operandA};
        rem_q   <= '0;
        quo_q   <= mag_a[WIDTH-1:0];
        dvsr_q  <= mag_b;
        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        divz_q  <= (data_operandB == '0);
        dovf_q  <= (data_operandA == INT_MIN) && (data_operandB == '1);
      end else begin
        case (state)
          MUL: begin
            acc     <= {booth_up[WIDTH], booth_up, acc[WIDTH:1]};
            counter <= counter_next;
            if (counter_next == 6'(ITER)) state <= DONE;
          end
          DIV: begin
            rem_q   <= rem_next;
            quo_q   <= {quo_q[WIDTH-2:0], q_bit};
            counter <= counter_next;
            if (counter_next == 6'(ITER)) state <= DONE;
          end
          DONE: begin
            if (op_q == OP_MUL) begin
              data_result    <= product[WIDTH-1:0];
              data_exception <= mul_ovf;
            end else begin
              data_result    <= div_res;
              data_exception <= divz_q | dovf_q;
            end
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference from plain signed math.
  function automatic void model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  // Timing reference: a start schedules delivery 33 edges later; a newer
  // start replaces the pending one; reset discards everything.
  logic        m_pend, m_rdy, m_exc, p_exc;
  logic [31:0] m_res, p_res;
  longint      m_cyc, m_due;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 1'b0;
      m_rdy  = 1'b0;
      m_res  = 32'd0;
      m_exc  = 1'b0;
      m_cyc  = 0;
      m_due  = 0;
    end else begin
      m_cyc++;
      m_rdy = 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        model(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
        m_pend = 1'b1;
        m_due  = m_cyc + 33;
      end else if (m_pend && m_cyc == m_due) begin
        m_pend = 1'b0;
        m_rdy  = 1'b1;
        m_res  = p_res;
        m_exc  = p_exc;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc rdy", 32'(data_resultRDY), 32'(m_rdy));
      chk("cyc busy", 32'(busy), 32'(m_pend));
      chk("cyc result", data_result, m_res);
      chk("cyc exc", 32'(data_exception), 32'(m_exc));
    end
  end

  task automatic run_op(input logic is_mul, input logic both, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee,
                        input string name);
    logic [31:0] mr;
    logic        me;
    int          lat;
    model(is_mul, a, b, mr, me);
    chk({name, " model res"}, mr, er);
    chk({name, " model exc"}, 32'(me), 32'(ee));
    @(negedge clock);
    ctrl_MULT     = is_mul | both;
    ctrl_DIV      = ~is_mul | both;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd33);
    chk({name, " result"}, data_result, er);
    chk({name, " exc"}, 32'(data_exception), 32'(ee));
    @(negedge clock);
    chk({name, " rdy cleared"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    reset_n       = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset result", data_result, 32'd0);
    chk("reset exc", 32'(data_exception), 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    run_op(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "mul 7*-6");
    run_op(1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, "mul ovf 2^32");
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0, "mul max*1");
    run_op(1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul min*-1");
    run_op(1'b0, 1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, "div -100/7");
    run_op(1'b0, 1'b0, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, "div 100/-10");
    run_op(1'b0, 1'b0, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, "div min/2");
    run_op(1'b0, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, "div min/1");
    run_op(1'b0, 1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1, "div 5/0");
    run_op(1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div min/-1");
    run_op(1'b1, 1'b1, 32'd6,          32'd3,         32'd18,        1'b0, "both 6,3");

    // Restart: MUL 3*4 at E0, DIV 100/10 at E10.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd10;
    @(negedge clock);
    ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    lat = 0;
    pulses = 0;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("restart latency", 32'(lat), 32'd33);
    chk("restart result", data_result, 32'd10);
    chk("restart exc", 32'(data_exception), 32'd0);
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("restart extra pulses", 32'(pulses), 32'd0);

    // Reset mid-operation at E15.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (15) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset exc", 32'(data_exception), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset rdy", 32'(data_resultRDY), 32'd0);
    #4 reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("midreset no pulse", 32'(pulses), 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
